// File: rtl/rf_ctrl_pkg.sv
// Shared types and default widths for the register-file access controller.
// Holds the FSM state encoding and the packed request layout.
package rf_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP,
        INIT
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rf_access_ctrl.sv
// Single-command initiator for the flip-flop register file: request in, one RF strobe,
// response out. Define RF_INIT_EN to sweep INIT_VAL into every entry after reset.
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
`ifdef RF_INIT_EN
    ,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rf_din,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_wr,
    output logic              rf_rd,
    input  logic [DATA_W-1:0] rf_dout,
    input  logic              rf_error,
    output logic [CNT_W-1:0]  err_count
);

    state_t              state_reg;
    logic                req_ready_reg;
    logic                rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic                rsp_err_reg;
    logic [DATA_W-1:0]   rf_din_reg;
    logic [ADDR_W-1:0]   rf_addr_reg;
    logic                rf_wr_reg;
    logic                rf_rd_reg;
    logic [CNT_W-1:0]    err_count_reg;
    logic                cmd_wr_reg;
`ifdef RF_INIT_EN
    logic [ADDR_W-1:0]   init_addr_reg;
`endif

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign rf_din    = rf_din_reg;
    assign rf_addr   = rf_addr_reg;
    assign rf_wr     = rf_wr_reg;
    assign rf_rd     = rf_rd_reg;
    assign err_count = err_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            rf_din_reg    <= '0;
            rf_addr_reg   <= '0;
            rf_wr_reg     <= 1'b0;
            rf_rd_reg     <= 1'b0;
            err_count_reg <= '0;
            cmd_wr_reg    <= 1'b0;
`ifdef RF_INIT_EN
            init_addr_reg <= '0;
            state_reg     <= INIT;
`else
            state_reg     <= IDLE;
`endif
        end else begin
            rf_wr_reg <= 1'b0;
            rf_rd_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid && req_ready_reg) begin
                        // Strobes are registered here so they are visible for the whole
                        // ISSUE cycle; rf_addr/rf_din double as the command latch.
                        cmd_wr_reg    <= req_wr;
                        rf_addr_reg   <= req_addr;
                        rf_din_reg    <= req_wdata;
                        rf_wr_reg     <= req_wr;
                        rf_rd_reg     <= ~req_wr;
                        req_ready_reg <= 1'b0;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_err_reg   <= rf_error;
                    rsp_rdata_reg <= (!cmd_wr_reg && !rf_error) ? rf_dout : '0;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                        if (rsp_err_reg && (err_count_reg != {CNT_W{1'b1}})) begin
                            err_count_reg <= err_count_reg + 1'b1;
                        end
                    end
                end
`ifdef RF_INIT_EN
                INIT: begin
                    rf_wr_reg     <= 1'b1;
                    rf_addr_reg   <= init_addr_reg;
                    rf_din_reg    <= INIT_VAL;
                    init_addr_reg <= init_addr_reg + 1'b1;
                    // req_ready rises from IDLE one cycle later, after the last write.
                    if (init_addr_reg == {ADDR_W{1'b1}}) begin
                        state_reg <= IDLE;
                    end
                end
`endif
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
